// File: rtl/mem_arb_if.sv
// mem_arb_if: bundles the fetch, load/store and bus-side signals of mem_arb.
// Signal suffixes are from the arbiter's point of view. The arbiter uses the
// slave modport; requesters and the bus slave together use the master modport.
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // fetch side
  logic            if_req_i;
  logic [AW-1:0]   if_addr_i;
  logic            if_ack_o;
  logic [DW-1:0]   if_rdata_o;
  logic            if_stallreq_o;
  // load/store side
  logic            ls_req_i;
  logic            ls_we_i;
  logic [AW-1:0]   ls_addr_i;
  logic [DW-1:0]   ls_wdata_i;
  logic [DW/8-1:0] ls_wstrb_i;
  logic            ls_ack_o;
  logic [DW-1:0]   ls_rdata_o;
  logic            ls_stallreq_o;
  // shared bus port
  logic            bus_req_o;
  logic            bus_we_o;
  logic [AW-1:0]   bus_addr_o;
  logic [DW-1:0]   bus_wdata_o;
  logic [DW/8-1:0] bus_wstrb_o;
  logic            bus_ack_i;
  logic [DW-1:0]   bus_rdata_i;
  logic            err_o;

  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
           ls_wstrb_i, bus_ack_i, bus_rdata_i,
    output if_ack_o, if_rdata_o, if_stallreq_o, ls_ack_o, ls_rdata_o,
           ls_stallreq_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
           bus_wstrb_o, err_o
  );

  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i,
           ls_wstrb_i, bus_ack_i, bus_rdata_i,
    input  if_ack_o, if_rdata_o, if_stallreq_o, ls_ack_o, ls_rdata_o,
           ls_stallreq_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
           bus_wstrb_o, err_o
  );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: shares one bus port between instruction fetch (if) and load/store
// (ls). ls has fixed priority; after LS_BURST_MAX back-to-back ls grants with
// a fetch waiting, the fetch is forced through. Every transaction is
// grant -> hold until bus ack -> one idle bubble.
// Optional: define ARB_TIMEOUT_EN to abort a transaction that waits
// TIMEOUT_CYCLES without a bus ack (owner acked with zero data, err_o pulse).
module mem_arb #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int LS_BURST_MAX   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic      clk,
  input logic      rst_n,
  mem_arb_if.slave arb
);
  localparam int SW  = DW / 8;
  localparam int BCW = $clog2(LS_BURST_MAX + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] LS_BUSY = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;

  logic tmo;       // wait limit reached in a busy state
  logic done;      // current transaction ends this cycle
  logic ls_grant;  // ls wins IDLE arbitration this cycle

`ifdef ARB_TIMEOUT_EN
  localparam int WCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WCW-1:0] wait_q, wait_d;

  assign tmo = (state_q != IDLE) && (wait_q == WCW'(TIMEOUT_CYCLES));

  // wait counter: held at zero in IDLE so every transaction starts from 0
  always_comb begin
    wait_d = '0;
    if (state_q != IDLE) wait_d = wait_q + 1'b1;
  end

  // wait counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  // without the counter the limit has no effect; a busy state waits forever
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = |TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  assign done     = arb.bus_ack_i | tmo;
  assign ls_grant = arb.ls_req_i &
                    ~(arb.if_req_i & (burst_q == BCW'(LS_BURST_MAX)));

  // owner ack/data are combinational in the ack cycle; a real bus ack beats a
  // same-cycle timeout, so data only comes through on a genuine ack
  assign arb.if_ack_o   = (state_q == IF_BUSY) & done;
  assign arb.ls_ack_o   = (state_q == LS_BUSY) & done;
  assign arb.if_rdata_o = ((state_q == IF_BUSY) & arb.bus_ack_i) ? arb.bus_rdata_i : '0;
  assign arb.ls_rdata_o = ((state_q == LS_BUSY) & arb.bus_ack_i) ? arb.bus_rdata_i : '0;
  assign arb.err_o      = tmo & ~arb.bus_ack_i;

  assign arb.if_stallreq_o = arb.if_req_i & ~arb.if_ack_o;
  assign arb.ls_stallreq_o = arb.ls_req_i & ~arb.ls_ack_o;

  assign arb.bus_req_o   = req_q;
  assign arb.bus_we_o    = we_q;
  assign arb.bus_addr_o  = addr_q;
  assign arb.bus_wdata_o = wdata_q;
  assign arb.bus_wstrb_o = wstrb_q;

  // arbitration in IDLE, hold-until-ack in the busy states
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      IDLE: begin
        if (ls_grant) begin
          req_d   = 1'b1;
          we_d    = arb.ls_we_i;
          addr_d  = arb.ls_addr_i;
          wdata_d = arb.ls_wdata_i;
          wstrb_d = arb.ls_wstrb_i;
          state_d = LS_BUSY;
          // only grants that made a fetch wait count toward the burst limit
          burst_d = arb.if_req_i ? burst_q + 1'b1 : '0;
        end else if (arb.if_req_i) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = arb.if_addr_i;
          wstrb_d = '0;
          state_d = IF_BUSY;
          burst_d = '0;
        end else begin
          req_d   = 1'b0;
          burst_d = '0;
        end
      end
      IF_BUSY, LS_BUSY: begin
        if (done) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // state and registered bus outputs; reset drops bus_req_o immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      burst_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end
endmodule
